// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU and its datapath.
package alu_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD  = 4'b0000,
    CMD_SUB  = 4'b0001,
    CMD_NOT  = 4'b0010,
    CMD_CMP  = 4'b0011,
    CMD_MOVL = 4'b0100,
    CMD_MOVR = 4'b0101,
    CMD_AND  = 4'b0110,
    CMD_OR   = 4'b0111,
    CMD_ADC  = 4'b1000,
    CMD_SHL  = 4'b1001,
    CMD_SHR  = 4'b1010,
    CMD_XOR  = 4'b1011,
    CMD_RSV0 = 4'b1100,
    CMD_RSV1 = 4'b1101,
    CMD_RSV2 = 4'b1110,
    CMD_RSV3 = 4'b1111
  } alu_cmd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift(alu_cmd_e c);
    return (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/complete bus between the register-read stage, the ALU and writeback.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] alu_cmd;
  logic [W-1:0]     inA;
  logic [W-1:0]     inB;
  logic             out_valid;
  logic [W-1:0]     rslt;
  logic             flag;

  modport master (
    output in_valid, alu_cmd, inA, inB,
    input  in_ready, out_valid, rslt, flag
  );

  modport slave (
    input  in_valid, alu_cmd, inA, inB,
    output in_ready, out_valid, rslt, flag
  );

endinterface

// File: rtl/alu_core.sv
// Single-cycle combinational datapath; shift opcodes are iterated by alu_seq and return zero here.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  alu_cmd_e     cmd,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] rslt,
  output logic         flag
);

  logic [W:0]   add_sum;
  logic [W:0]   sub_diff;
  logic [W-1:0] and_v;
  logic [W-1:0] or_v;
  logic [W-1:0] xor_v;
  logic [W-1:0] not_v;

  // Carry-in only participates for ADC so plain ADD stays independent of history.
  assign add_sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin & (cmd == CMD_ADC)};
  assign sub_diff = {1'b0, a} - {1'b0, b};

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign and_v[gi] = a[gi] & b[gi];
    assign or_v[gi]  = a[gi] | b[gi];
    assign xor_v[gi] = a[gi] ^ b[gi];
    assign not_v[gi] = ~a[gi];
  end

  always_comb begin
    rslt = '0;
    flag = 1'b0;
    case (cmd)
      CMD_ADD, CMD_ADC: begin
        rslt = add_sum[W-1:0];
        flag = add_sum[W];
      end
      CMD_SUB: begin
        rslt = sub_diff[W-1:0];
        flag = sub_diff[W];
      end
      CMD_NOT:  rslt = not_v;
      CMD_CMP:  flag = (a == b);
      CMD_MOVL: rslt = b;
      CMD_MOVR: rslt = a;
      CMD_AND:  rslt = and_v;
      CMD_OR:   rslt = or_v;
      CMD_XOR:  rslt = xor_v;
      default: begin
        rslt = '0;
        flag = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registers every result/flag, iterates shifts one bit per clock,
// and feeds the registered flag back as ADC carry-in.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(W);

  alu_state_e     state_reg, state_next;
  logic [W-1:0]   acc_reg;
  logic [SHW-1:0] cnt_reg;
  logic           dir_reg;
  logic           sbit_reg;
  logic [W-1:0]   rslt_reg;
  logic           flag_reg;
  logic           out_valid_reg;

  alu_cmd_e       cmd;
  logic [W-1:0]   core_rslt;
  logic           core_flag;
  logic           in_ready;
  logic           accept;
  logic           cmd_shift;

  assign cmd = alu_cmd_e'(bus.alu_cmd);

  alu_core #(.W(W)) u_core (
    .cmd  (cmd),
    .a    (bus.inA),
    .b    (bus.inB),
    .cin  (flag_reg),
    .rslt (core_rslt),
    .flag (core_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && cmd_shift) state_next = SHIFT;
      SHIFT:   if (cnt_reg == '0)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    accept    = bus.in_valid && in_ready;
    cmd_shift = is_shift(cmd);
  end

  // Shift datapath and output registers; sbit_reg holds the most recent bit shifted out.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      dir_reg       <= 1'b0;
      sbit_reg      <= 1'b0;
      rslt_reg      <= '0;
      flag_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (cmd_shift) begin
              acc_reg  <= bus.inA;
              cnt_reg  <= bus.inB[SHW-1:0];
              dir_reg  <= (cmd == CMD_SHR);
              sbit_reg <= 1'b0;
            end else begin
              rslt_reg      <= core_rslt;
              flag_reg      <= core_flag;
              out_valid_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt_reg != '0) begin
            acc_reg  <= dir_reg ? {1'b0, acc_reg[W-1:1]} : {acc_reg[W-2:0], 1'b0};
            sbit_reg <= dir_reg ? acc_reg[0] : acc_reg[W-1];
            cnt_reg  <= cnt_reg - 1'b1;
          end else begin
            rslt_reg      <= acc_reg;
            flag_reg      <= sbit_reg;
            out_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.rslt      = rslt_reg;
  assign bus.flag      = flag_reg;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU. It is width-generic (`W`), registers its result and flag, and chains multi-word arithmetic through a carry flag (ADC). It adds XOR and multi-cycle barrel-free shifts that iterate one bit per clock. It sits between the register-file read stage and writeback; the controller issues on `in_valid`/`in_ready` and captures on the `out_valid` pulse.

## Interface
- `W`, default 8: datapath width; power of two, at least 4.
- `SHW`, default `$clog2(W)`: shift-amount width (derived; not overridden).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: operation present on `alu_cmd`/`inA`/`inB`.
- `in_ready`  out  1: block accepts an operation this cycle.
- `alu_cmd`  in  4: opcode.
- `inA`  in  W: operand A.
- `inB`  in  W: operand B; also carries the immediate for ADDI (issued as ADD) and the shift amount in `inB[SHW-1:0]`.
- `out_valid`  out  1: one-cycle pulse; `rslt`/`flag` are new this cycle.
- `rslt`  out  W: registered result; holds until the next completion.
- `flag`  out  1: registered status flag; holds until the next completion.

## Operation
- Opcodes and results:
  - 0000 ADD: `rslt=A+B`; `flag`=carry-out.
  - 0001 SUB: `rslt=A-B` mod 2^W; `flag`=borrow (A<B unsigned).
  - 0010 NOT: `rslt=~A`.
  - 0011 CMP: `rslt=0`; `flag=(A==B)`.
  - 0100 MOVL: `rslt=B`.
  - 0101 MOVR: `rslt=A`.
  - 0110 AND.
  - 0111 OR.
  - 1000 ADC: `rslt=A+B+flag` (current registered flag); `flag`=carry-out.
  - 1001 SHL: logical left shift.
  - 1010 SHR: logical right shift.
  - 1011 XOR.
  - 1100–1111 reserved: `rslt=0`, `flag=0`, `out_valid` still pulses.
- `flag=0` for NOT, MOVL, MOVR, AND, OR, XOR. Every completion writes `flag`.
- Shifts:
  - Amount n = `inB[SHW-1:0]`; upper bits of `inB` are ignored.
  - Zero fill; one bit per cycle.
  - `flag` = last bit shifted out; `flag=0` when n=0.
- FSM:
  - IDLE (`in_ready=1`):
    - accept of a non-shift op → write `rslt`/`flag`, `out_valid=1`, stay IDLE;
    - accept of a shift → latch acc←A, cnt←n, dir, go to SHIFT.
  - SHIFT (`in_ready=0`):
    - cnt≠0 → shift acc by one, cnt--, capture the bit shifted out;
    - cnt=0 → `rslt←acc`, `flag`←captured bit, `out_valid=1`, go to IDLE.
- `in_valid` while `in_ready=0` is ignored; the issuer holds it until accepted.
- No output backpressure; the consumer must take the `out_valid` pulse.

## Timing
- Reset values: `rslt=0`, `flag=0`, `out_valid=0`, `in_ready=1`, state IDLE, cnt=0.
- Non-shift latency: accepted at edge k → `out_valid` high for the cycle after k. Throughput is 1 op per cycle with no bubble.
- Shift latency: accepted at edge k → `out_valid` after edge k+n+1.
  - `in_ready` is low from edge k through edge k+n+1.
  - The next op is accepted at edge k+n+2 at the earliest.
- ADC reads the flag produced by the immediately preceding completion, including back-to-back issue.
- Reset mid-SHIFT: abort on that edge and return to reset values. No late `out_valid` for the aborted shift.
- Reset with `in_valid` asserted: the op is not accepted.

## Structure
- Package `alu_pkg`:
  - `alu_cmd_e` enum (4-bit, values above);
  - `CMD_W=4`;
  - FSM state enum `alu_state_e` {IDLE, SHIFT}.
- Sub-module `alu_core`: purely combinational single-cycle datapath, parametrised by `W`. It takes cmd, A, B and carry-in, and produces `rslt` and `flag`.
- `alu_seq` owns the handshake, FSM, shift accumulator/counter and the output registers.

## Test plan (W=8)
- ADD 255+1 accepted at edge k → after edge k+1: `out_valid=1`, `rslt=0`, `flag=1`; `out_valid=0` the following cycle.
- Back-to-back issue, 16-bit add 0x00FF+0x0001:
  - ADD 0xFF,0x01 → `rslt=0x00`, `flag=1`;
  - then ADC 0x00,0x00 → `rslt=0x01`, `flag=0`.
- SUB 5−7 → `rslt=254`, `flag=1`; CMP 27,27 → `rslt=0`, `flag=1`; CMP 27,26 → `flag=0`.
- SHL 0b1011_0001 by 3:
  - `in_ready` low 4 cycles;
  - `out_valid` after edge k+4 with `rslt=0b1000_1000`, `flag=1`.
  - SHR 0x80 by 0 → `rslt=0x80`, `flag=0` after edge k+1.
- `in_valid` held every cycle with AND, OR, XOR on A=0b0010_1111, B=0b1011_0010 → three consecutive `out_valid` cycles with `rslt` 0b0010_0010, 0b1011_1111, 0b1001_1101, all `flag=0`.
- SHR 0xFF by 7, `reset` asserted 3 cycles after accept:
  - next cycle `rslt=0`, `flag=0`, `out_valid=0`, `in_ready=1`;
  - no `out_valid` in the following 10 cycles;
  - opcode 1111 → `rslt=0`, `flag=0`, `out_valid` pulses.
